// File: rtl/denoise_frame_sync.sv
// rtl/denoise_frame_sync.sv - aligns previous-frame and current-frame pixel streams into pairs for the denoise core
//
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   s_prev_axis_*                      previous-frame stream from the frame buffer (tdata/tvalid/tready/tlast/tuser)
//   s_curr_axis_*                      current-frame stream from the video input (tdata/tvalid/tready/tlast/tuser)
//   m_prev_tdata, m_curr_tdata         aligned pixel pair to the denoise core
//   m_axis_tvalid/tready/tlast/tuser   pair handshake, end-of-line, start-of-frame
//   output_mode_in / output_mode_out   mode from the register bank / frame-stable copy to the core
//   locked                             high while the two streams are aligned
//   sync_err                           one-cycle pulse when a misaligned pair is seen
//   drop_cnt                           beats discarded while hunting (saturating)
//
// Build option: FSYNC_DROP_CNT_EN - when defined, drop_cnt counts dropped beats;
// otherwise drop_cnt is tied to zero and no counter is built.

module denoise_frame_sync #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
  input  logic                  s_prev_axis_tvalid,
  input  logic                  s_prev_axis_tlast,
  input  logic                  s_prev_axis_tuser,
  output logic                  s_prev_axis_tready,

  input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
  input  logic                  s_curr_axis_tvalid,
  input  logic                  s_curr_axis_tlast,
  input  logic                  s_curr_axis_tuser,
  output logic                  s_curr_axis_tready,

  output logic [DATA_WIDTH-1:0] m_prev_tdata,
  output logic [DATA_WIDTH-1:0] m_curr_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,

  input  logic [1:0]            output_mode_in,
  output logic [1:0]            output_mode_out,

  output logic                  locked,
  output logic                  sync_err,
  output logic [15:0]           drop_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  logic prev_drop;
  logic curr_drop;
  logic both_sof;
  logic load;
  logic pair_ok;

  always_comb begin
    prev_drop = 1'b0;
    curr_drop = 1'b0;
    both_sof  = 1'b0;
    load      = 1'b0;
    pair_ok   = 1'b0;

    // While hunting, non-SOF beats are flushed; an SOF beat is held at the head
    // until the other stream also presents its SOF.
    if (state == HUNT) begin
      prev_drop = s_prev_axis_tvalid && !s_prev_axis_tuser;
      curr_drop = s_curr_axis_tvalid && !s_curr_axis_tuser;
      both_sof  = s_prev_axis_tvalid && s_prev_axis_tuser &&
                  s_curr_axis_tvalid && s_curr_axis_tuser;
    end else begin
      load = s_prev_axis_tvalid && s_curr_axis_tvalid &&
             (!m_axis_tvalid || m_axis_tready);
    end

    pair_ok = (s_prev_axis_tlast == s_curr_axis_tlast) &&
              (s_prev_axis_tuser == s_curr_axis_tuser);
  end

  // Both inputs are consumed together in RUN so the streams can never slip.
  assign s_prev_axis_tready = aresetn && ((state == RUN) ? load : prev_drop);
  assign s_curr_axis_tready = aresetn && ((state == RUN) ? load : curr_drop);

  assign locked = (state == RUN);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= HUNT;
      m_prev_tdata    <= '0;
      m_curr_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      output_mode_out <= 2'd0;
      sync_err        <= 1'b0;
    end else begin
      sync_err <= 1'b0;

      if (load) begin
        if (pair_ok) begin
          m_prev_tdata  <= s_prev_axis_tdata;
          m_curr_tdata  <= s_curr_axis_tdata;
          m_axis_tlast  <= s_curr_axis_tlast;
          m_axis_tuser  <= s_curr_axis_tuser;
          m_axis_tvalid <= 1'b1;
          // Mode only changes on a frame boundary so the core never sees a mid-frame switch.
          if (s_curr_axis_tuser) begin
            output_mode_out <= output_mode_in;
          end
        end else begin
          // Misaligned pair is swallowed; any beat already in the output register still drains.
          sync_err <= 1'b1;
          state    <= HUNT;
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (both_sof) begin
        state <= RUN;
      end
    end
  end

`ifdef FSYNC_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  always_comb begin
    drop_inc = {1'b0, prev_drop} + {1'b0, curr_drop};
    drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      drop_cnt_q <= 16'd0;
    end else if (drop_sum[16]) begin
      drop_cnt_q <= 16'hFFFF;
    end else begin
      drop_cnt_q <= drop_sum[15:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_denoise_frame_sync.sv
// tb/tb_denoise_frame_sync.sv - directed self-checking bench for denoise_frame_sync
`timescale 1ns/1ps

module tb_denoise_frame_sync;

  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_prev_axis_tdata, s_curr_axis_tdata;
  logic          s_prev_axis_tvalid, s_prev_axis_tlast, s_prev_axis_tuser, s_prev_axis_tready;
  logic          s_curr_axis_tvalid, s_curr_axis_tlast, s_curr_axis_tuser, s_curr_axis_tready;
  logic [DW-1:0] m_prev_tdata, m_curr_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready;
  logic [1:0]    output_mode_in, output_mode_out;
  logic          locked, sync_err;
  logic [15:0]   drop_cnt;

  always #5 aclk = ~aclk;

  denoise_frame_sync #(.DATA_WIDTH(DW)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_prev_axis_tdata  (s_prev_axis_tdata),
    .s_prev_axis_tvalid (s_prev_axis_tvalid),
    .s_prev_axis_tlast  (s_prev_axis_tlast),
    .s_prev_axis_tuser  (s_prev_axis_tuser),
    .s_prev_axis_tready (s_prev_axis_tready),
    .s_curr_axis_tdata  (s_curr_axis_tdata),
    .s_curr_axis_tvalid (s_curr_axis_tvalid),
    .s_curr_axis_tlast  (s_curr_axis_tlast),
    .s_curr_axis_tuser  (s_curr_axis_tuser),
    .s_curr_axis_tready (s_curr_axis_tready),
    .m_prev_tdata       (m_prev_tdata),
    .m_curr_tdata       (m_curr_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tready      (m_axis_tready),
    .output_mode_in     (output_mode_in),
    .output_mode_out    (output_mode_out),
    .locked             (locked),
    .sync_err           (sync_err),
    .drop_cnt           (drop_cnt)
  );

  typedef logic [DW+1:0] beat_t;  // {tuser, tlast, tdata}
  typedef struct packed {
    logic [DW-1:0] p;
    logic [DW-1:0] c;
    logic          last;
    logic          user;
  } pair_t;

  beat_t prev_q[$];
  beat_t curr_q[$];
  pair_t got_q[$];

  int   checks = 0;
  int   errors = 0;
  logic tog_en = 1'b0;
  int   sync_cnt = 0;
  logic sync_locked = 1'b1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int exp_drop(input int n);
`ifdef FSYNC_DROP_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // Source drivers and ready toggler: update just after each rising edge.
  initial begin : drv
    logic ph, ch;
    s_prev_axis_tvalid = 1'b0; s_prev_axis_tdata = '0; s_prev_axis_tlast = 1'b0; s_prev_axis_tuser = 1'b0;
    s_curr_axis_tvalid = 1'b0; s_curr_axis_tdata = '0; s_curr_axis_tlast = 1'b0; s_curr_axis_tuser = 1'b0;
    forever begin
      @(posedge aclk);
      ph = s_prev_axis_tvalid && s_prev_axis_tready;
      ch = s_curr_axis_tvalid && s_curr_axis_tready;
      #1;
      if (ph && prev_q.size() > 0) void'(prev_q.pop_front());
      if (ch && curr_q.size() > 0) void'(curr_q.pop_front());
      if (tog_en) m_axis_tready = ~m_axis_tready;
      s_prev_axis_tvalid = (prev_q.size() > 0);
      if (prev_q.size() > 0) {s_prev_axis_tuser, s_prev_axis_tlast, s_prev_axis_tdata} = prev_q[0];
      else {s_prev_axis_tuser, s_prev_axis_tlast, s_prev_axis_tdata} = '0;
      s_curr_axis_tvalid = (curr_q.size() > 0);
      if (curr_q.size() > 0) {s_curr_axis_tuser, s_curr_axis_tlast, s_curr_axis_tdata} = curr_q[0];
      else {s_curr_axis_tuser, s_curr_axis_tlast, s_curr_axis_tdata} = '0;
    end
  end

  // Output monitor: collects accepted pairs, checks stall stability and backpressure.
  logic          stall = 1'b0;
  logic [DW-1:0] sp, sc;
  logic          sl, su;

  always @(posedge aclk) begin
    if (aresetn) begin
      if (stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data", {m_prev_tdata, m_curr_tdata}, {sp, sc});
        check("stall_flags", 64'({m_axis_tlast, m_axis_tuser}), 64'({sl, su}));
      end
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back({m_prev_tdata, m_curr_tdata, m_axis_tlast, m_axis_tuser});
      if (locked && m_axis_tvalid && !m_axis_tready)
        check("full_tready", 64'({s_prev_axis_tready, s_curr_axis_tready}), 64'd0);
      if (sync_err) begin
        sync_cnt    <= sync_cnt + 1;
        sync_locked <= locked;
      end
    end
    stall <= aresetn && m_axis_tvalid && !m_axis_tready;
    sp    <= m_prev_tdata;
    sc    <= m_curr_tdata;
    sl    <= m_axis_tlast;
    su    <= m_axis_tuser;
  end

  task automatic push_frame(input bit to_curr, input int tag, input int first_last);
    beat_t b;
    for (int i = 0; i < 12; i++) begin
      b = {(i == 0), (i == first_last || i == 7 || i == 11),
           (to_curr ? 8'hC0 : 8'hA0), 8'(tag), 16'(i)};
      if (to_curr) curr_q.push_back(b);
      else prev_q.push_back(b);
    end
  endtask

  task automatic check_frame(input int start, input int tag, input int n);
    pair_t g;
    for (int i = 0; i < n; i++) begin
      if (start + i < got_q.size()) begin
        g = got_q[start + i];
        check($sformatf("t%0d_pair%0d_prev", tag, i), 64'(g.p), 64'({8'hA0, 8'(tag), 16'(i)}));
        check($sformatf("t%0d_pair%0d_curr", tag, i), 64'(g.c), 64'({8'hC0, 8'(tag), 16'(i)}));
        check($sformatf("t%0d_pair%0d_last", tag, i), 64'(g.last), 64'(i == 3 || i == 7 || i == 11));
        check($sformatf("t%0d_pair%0d_user", tag, i), 64'(g.user), 64'(i == 0));
      end else begin
        check($sformatf("t%0d_pair%0d_missing", tag, i), 64'd0, 64'd1);
      end
    end
  endtask

  task automatic wait_pairs(input int n);
    int k = 0;
    while (got_q.size() < n && k < 2000) begin
      @(negedge aclk);
      k++;
    end
    check($sformatf("wait_pairs_%0d", n), 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tog_en = 1'b0;
    m_axis_tready = 1'b1;
    prev_q.delete();
    curr_q.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_flags"}, 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
    check({tag, "_data"}, {m_prev_tdata, m_curr_tdata}, 64'd0);
    check({tag, "_s_tready"}, 64'({s_prev_axis_tready, s_curr_axis_tready}), 64'd0);
    check({tag, "_mode"}, 64'(output_mode_out), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_sync_err"}, 64'(sync_err), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sync_base;
    int rem;
    m_axis_tready = 1'b1;
    output_mode_in = 2'd0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset");
    aresetn = 1'b1;

    // Aligned 4x3 frame, sink always ready.
    sync_base = sync_cnt;
    push_frame(1'b0, 1, 3);
    push_frame(1'b1, 1, 3);
    wait_pairs(12);
    repeat (4) @(negedge aclk);
    check("aligned_count", 64'(got_q.size()), 64'd12);
    check_frame(0, 1, 12);
    check("aligned_locked", 64'(locked), 64'd1);
    check("aligned_drop", 64'(drop_cnt), 64'd0);
    check("aligned_sync", 64'(sync_cnt - sync_base), 64'd0);

    // Current stream preceded by five non-SOF beats.
    do_reset();
    for (int k = 0; k < 5; k++) curr_q.push_back({1'b0, 1'b0, 32'hDEAD0000 + 32'(k)});
    push_frame(1'b0, 2, 3);
    push_frame(1'b1, 2, 3);
    wait_pairs(12);
    repeat (4) @(negedge aclk);
    check("hunt_count", 64'(got_q.size()), 64'd12);
    check_frame(0, 2, 12);
    check("hunt_drop", 64'(drop_cnt), 64'(exp_drop(5)));

    // Sink ready toggling every cycle.
    do_reset();
    tog_en = 1'b1;
    push_frame(1'b0, 3, 3);
    push_frame(1'b1, 3, 3);
    wait_pairs(12);
    repeat (8) @(negedge aclk);
    check("toggle_count", 64'(got_q.size()), 64'd12);
    check_frame(0, 3, 12);
    tog_en = 1'b0;
    m_axis_tready = 1'b1;

    // Line-end mismatch at beat 4, then relock on the next common SOF.
    do_reset();
    sync_base = sync_cnt;
    push_frame(1'b0, 4, 3);
    push_frame(1'b1, 4, 4);
    push_frame(1'b0, 5, 3);
    push_frame(1'b1, 5, 3);
    wait_pairs(15);
    repeat (4) @(negedge aclk);
    check("mis_count", 64'(got_q.size()), 64'd15);
    check_frame(0, 4, 3);
    check_frame(3, 5, 12);
    check("mis_sync_pulses", 64'(sync_cnt - sync_base), 64'd1);
    check("mis_locked_at_err", 64'(sync_locked), 64'd0);
    check("mis_relocked", 64'(locked), 64'd1);
    check("mis_drop", 64'(drop_cnt), 64'(exp_drop(16)));

    // Mode change mid-frame only takes effect at the next SOF pair.
    do_reset();
    output_mode_in = 2'd0;
    push_frame(1'b0, 6, 3);
    push_frame(1'b1, 6, 3);
    wait_pairs(6);
    output_mode_in = 2'd2;
    @(negedge aclk);
    check("mode_mid_frame", 64'(output_mode_out), 64'd0);
    wait_pairs(12);
    repeat (3) @(negedge aclk);
    check("mode_after_frame", 64'(output_mode_out), 64'd0);
    push_frame(1'b0, 7, 3);
    push_frame(1'b1, 7, 3);
    wait_pairs(24);
    check("mode_next_frame", 64'(output_mode_out), 64'd2);
    check_frame(12, 7, 12);

    // One-cycle reset mid-frame while the output holds a beat.
    got_q.delete();
    push_frame(1'b0, 8, 3);
    push_frame(1'b1, 8, 3);
    wait_pairs(5);
    check("midrst_tvalid_before", 64'(m_axis_tvalid), 64'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_outputs("midrst");
    aresetn = 1'b1;
    rem = prev_q.size() + curr_q.size();
    got_q.delete();
    push_frame(1'b0, 9, 3);
    push_frame(1'b1, 9, 3);
    @(negedge aclk);
    check("midrst_unlocked", 64'(locked), 64'd0);
    wait_pairs(12);
    repeat (4) @(negedge aclk);
    check("midrst_count", 64'(got_q.size()), 64'd12);
    check_frame(0, 9, 12);
    check("midrst_drop", 64'(drop_cnt), 64'(exp_drop(rem)));
    check("midrst_mode", 64'(output_mode_out), 64'd2);
    check("midrst_locked", 64'(locked), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/denoise_frame_sync.md
DENOISE_FRAME_SYNC -- requirements
Module: denoise_frame_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width of every tdata port.
REQ-002 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports s_prev_axis_tdata/tvalid/tlast/tuser  input  DATA_WIDTH/1/1/1  previous-frame stream from frame buffer.
REQ-005 SHALL have port s_prev_axis_tready  output  1  previous-frame stream ready.
REQ-006 SHALL have ports s_curr_axis_tdata/tvalid/tlast/tuser  input  DATA_WIDTH/1/1/1  current-frame stream from video input.
REQ-007 SHALL have port s_curr_axis_tready  output  1  current-frame stream ready.
REQ-008 SHALL have ports m_prev_tdata, m_curr_tdata  output  DATA_WIDTH each  aligned pixel pair to denoise core.
REQ-009 SHALL have ports m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  1 each  pair valid, end-of-line, start-of-frame.
REQ-010 SHALL have port m_axis_tready  input  1  core accepts pair.
REQ-011 SHALL have port output_mode_in  input  2  mode from register bank; port output_mode_out  output  2  frame-stable mode to core.
REQ-012 SHALL have port locked  output  1  high while streams are aligned; port sync_err  output  1  one-cycle misalignment pulse.
REQ-013 SHALL have port drop_cnt  output  16  beats discarded while hunting.

Function
REQ-014 SHALL implement two states, HUNT and RUN; locked = (state == RUN).
REQ-015 In HUNT, each input SHALL assert tready while its head beat is valid with tuser=0 (beat dropped) and SHALL deassert tready when its head beat has tuser=1 (beat held).
REQ-016 HUNT SHALL go to RUN on the cycle after both inputs present valid tuser=1 beats; no output beat is produced in HUNT.
REQ-017 In RUN, load = s_prev_axis_tvalid && s_curr_axis_tvalid && (!m_axis_tvalid || m_axis_tready); both s_*_tready SHALL equal load, so both beats are consumed in the same cycle.
REQ-018 On load, the output register SHALL capture both tdata, curr tlast and curr tuser; m_axis_tvalid rises the next cycle (latency 1); outputs SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-019 m_axis_tvalid SHALL clear on a cycle with m_axis_tready=1 and no load.
REQ-020 On load with prev.tlast != curr.tlast or prev.tuser != curr.tuser, the pair SHALL be consumed but not forwarded, sync_err SHALL pulse 1 cycle, state SHALL go to HUNT; an already-registered output beat drains normally.
REQ-021 output_mode_out SHALL update to output_mode_in only when a tuser=1 pair is loaded; it is held at all other times.
REQ-022 drop_cnt SHALL increment by 1 per dropped beat per stream (by 2 when both drop in one cycle) and saturate at 16'hFFFF.
REQ-023 Consecutive tuser=1 beats on one input in HUNT SHALL be held, never dropped.

Reset
REQ-024 While aresetn=0: state=HUNT, m_axis_tvalid/tlast/tuser=0, m_prev_tdata=m_curr_tdata=0, both s_*_tready=0, output_mode_out=0, locked=0, sync_err=0, drop_cnt=0.
REQ-025 Reset mid-frame SHALL discard the registered output beat; the block resumes hunting for tuser.

Configuration
REQ-026 With macro FSYNC_DROP_CNT_EN defined, drop_cnt SHALL count per REQ-022; without it, drop_cnt SHALL be constant 0 and no counter logic is built.

Verification
REQ-027 Both streams start with tuser=1 together, 4x3-pixel frame, m_axis_tready=1 -> 12 pairs, first with tuser=1, tlast on beats 4/8/12, locked=1, drop_cnt=0.
REQ-028 curr stream preceded by 5 tuser=0 beats -> 5 beats dropped, prev held, drop_cnt=5, first output pair tuser=1.
REQ-029 m_axis_tready toggled 1/0 every cycle -> no pair lost or duplicated, data stable while stalled, s_*_tready=0 when output full and not ready.
REQ-030 prev tlast at beat 4 and curr tlast at beat 5 -> sync_err pulse at beat 4, locked=0, relock on next common tuser.
REQ-031 output_mode_in changed 0->2 mid-frame -> output_mode_out stays 0 until next tuser pair load, then 2.
REQ-032 aresetn asserted 1 cycle mid-frame with m_axis_tvalid=1 -> all outputs per REQ-024, locked=0 until next common tuser.
